// File: rtl/wb_region_ctrl_if.sv
// Wishbone bundle around wb_region_ctrl: host port, neuro (s0) and matmul (s1) slave ports, error pulse.
// The controller connects through the slave modport; the host/slave environment uses master.
interface wb_region_ctrl_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   logic        s0_cyc_o;
   logic        s0_stb_o;
   logic        s0_we_o;
   logic [3:0]  s0_sel_o;
   logic [31:0] s0_adr_o;
   logic [31:0] s0_dat_o;
   logic        s0_ack_i;
   logic [31:0] s0_dat_i;

   logic        s1_cyc_o;
   logic        s1_stb_o;
   logic        s1_we_o;
   logic [3:0]  s1_sel_o;
   logic [31:0] s1_adr_o;
   logic [31:0] s1_dat_o;
   logic        s1_ack_i;
   logic [31:0] s1_dat_i;

   logic        err_irq_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      output s0_cyc_o, s0_stb_o, s0_we_o, s0_sel_o, s0_adr_o, s0_dat_o,
      input  s0_ack_i, s0_dat_i,
      output s1_cyc_o, s1_stb_o, s1_we_o, s1_sel_o, s1_adr_o, s1_dat_o,
      input  s1_ack_i, s1_dat_i,
      output err_irq_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      input  s0_cyc_o, s0_stb_o, s0_we_o, s0_sel_o, s0_adr_o, s0_dat_o,
      output s0_ack_i, s0_dat_i,
      input  s1_cyc_o, s1_stb_o, s1_we_o, s1_sel_o, s1_adr_o, s1_dat_o,
      output s1_ack_i, s1_dat_i,
      input  err_irq_o
   );
endinterface

// File: rtl/wb_region_ctrl.sv
// Registered Wishbone region controller: host cycles go to the neuro/matmul slave, the local status word or a null responder.
// Define WBCTRL_TIMEOUT_EN to build the stalled-slave timeout, DEAD_BEEF response, error status and err_irq_o.
module wb_region_ctrl #(
   parameter logic [31:0] NEURO_BASE     = 32'h3000_0000,
   parameter logic [31:0] MATMUL_BASE    = 32'h3100_0000,
   parameter logic [31:0] STAT_BASE      = 32'h3200_0000,
   parameter logic [31:0] REGION_MASK    = 32'hFFFF_F000,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input logic             wb_clk_i,
   input logic             wb_rst_i,
   wb_region_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state_q, state_d;
   logic              slv_q, slv_d;
   logic              ack_q, ack_d;
   logic [31:0]       rdat_q, rdat_d;
   logic [1:0]        cyc_q, cyc_d;
   logic [1:0]        we_q, we_d;
   logic [1:0][3:0]   sel_q, sel_d;
   logic [1:0][31:0]  adr_q, adr_d;
   logic [1:0][31:0]  wdat_q, wdat_d;

   logic [31:0]       masked_adr;
   logic              hit0, hit1, hit_stat;
   logic              slv_ack;
   logic [31:0]       slv_rdat;
   logic [31:0]       status_word;

`ifdef WBCTRL_TIMEOUT_EN
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic              err_slave_q, err_slave_d;
   logic              sticky_q, sticky_d;
   logic              irq_q, irq_d;

   assign status_word = {err_cnt_q, 14'b0, err_slave_q, sticky_q};
`else
   logic [CNT_W-1:0]  unused_timeout;

   assign status_word    = '0;
   assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
`endif

   assign masked_adr = bus.wbs_adr_i & REGION_MASK;
   assign hit0       = (masked_adr == NEURO_BASE);
   assign hit1       = (masked_adr == MATMUL_BASE);
   assign hit_stat   = (masked_adr == STAT_BASE);
   assign slv_ack    = slv_q ? bus.s1_ack_i : bus.s0_ack_i;
   assign slv_rdat   = slv_q ? bus.s1_dat_i : bus.s0_dat_i;

   // Next-state logic; every accepted request clears both slave field sets so the idle slave reads back 0.
   always_comb begin
      state_d = state_q;
      slv_d   = slv_q;
      ack_d   = 1'b0;
      rdat_d  = rdat_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
`ifdef WBCTRL_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_cnt_d   = err_cnt_q;
      err_slave_d = err_slave_q;
      sticky_d    = sticky_q;
      irq_d       = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.wbs_cyc_i && bus.wbs_stb_i && !ack_q) begin
               cyc_d  = '0;
               we_d   = '0;
               sel_d  = '0;
               adr_d  = '0;
               wdat_d = '0;
               rdat_d = '0;
               if (hit0 || hit1) begin
                  slv_d          = hit1;
                  cyc_d[hit1]    = 1'b1;
                  we_d[hit1]     = bus.wbs_we_i;
                  sel_d[hit1]    = bus.wbs_sel_i;
                  adr_d[hit1]    = bus.wbs_adr_i;
                  wdat_d[hit1]   = bus.wbs_dat_i;
`ifdef WBCTRL_TIMEOUT_EN
                  cnt_d          = '0;
`endif
                  state_d        = BUSY;
               end else begin
                  ack_d   = 1'b1;
                  state_d = RESP;
                  if (hit_stat) begin
                     if (bus.wbs_we_i) begin
`ifdef WBCTRL_TIMEOUT_EN
                        if (bus.wbs_dat_i[0] && bus.wbs_sel_i[0]) begin
                           err_cnt_d   = '0;
                           err_slave_d = 1'b0;
                           sticky_d    = 1'b0;
                        end
`endif
                     end else begin
                        rdat_d = status_word;
                     end
                  end
               end
            end
         end

         // A slave ack on the same edge as the timeout compare is treated as success.
         BUSY: begin
            if (slv_ack) begin
               rdat_d  = slv_rdat;
               cyc_d   = '0;
               ack_d   = 1'b1;
               state_d = RESP;
            end
`ifdef WBCTRL_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rdat_d      = 32'hDEAD_BEEF;
               cyc_d       = '0;
               sticky_d    = 1'b1;
               err_slave_d = slv_q;
               if (err_cnt_q != 16'hFFFF) begin
                  err_cnt_d = err_cnt_q + 16'd1;
               end
               irq_d       = 1'b1;
               ack_d       = 1'b1;
               state_d     = RESP;
            end
`endif
            else if (!bus.wbs_cyc_i) begin
               cyc_d   = '0;
               state_d = IDLE;
            end
`ifdef WBCTRL_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         slv_q   <= 1'b0;
         ack_q   <= 1'b0;
         rdat_q  <= '0;
         cyc_q   <= '0;
         we_q    <= '0;
         sel_q   <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
`ifdef WBCTRL_TIMEOUT_EN
         cnt_q       <= '0;
         err_cnt_q   <= '0;
         err_slave_q <= 1'b0;
         sticky_q    <= 1'b0;
         irq_q       <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         slv_q   <= slv_d;
         ack_q   <= ack_d;
         rdat_q  <= rdat_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
`ifdef WBCTRL_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_slave_q <= err_slave_d;
         sticky_q    <= sticky_d;
         irq_q       <= irq_d;
`endif
      end
   end

   assign bus.wbs_ack_o = ack_q;
   assign bus.wbs_dat_o = rdat_q;

   assign bus.s0_cyc_o  = cyc_q[0];
   assign bus.s0_stb_o  = cyc_q[0];
   assign bus.s0_we_o   = we_q[0];
   assign bus.s0_sel_o  = sel_q[0];
   assign bus.s0_adr_o  = adr_q[0];
   assign bus.s0_dat_o  = wdat_q[0];

   assign bus.s1_cyc_o  = cyc_q[1];
   assign bus.s1_stb_o  = cyc_q[1];
   assign bus.s1_we_o   = we_q[1];
   assign bus.s1_sel_o  = sel_q[1];
   assign bus.s1_adr_o  = adr_q[1];
   assign bus.s1_dat_o  = wdat_q[1];

`ifdef WBCTRL_TIMEOUT_EN
   assign bus.err_irq_o = irq_q;
`else
   assign bus.err_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_region_ctrl.sv
// Scoreboard bench for wb_region_ctrl: host transactions push expected data/latency, acks pop and compare.
// Slave responders are programmable per test (wait states, never-ack, rogue ack on the idle slave).
module tb_wb_region_ctrl;

   localparam int TO = 8;

   logic wb_clk_i;
   logic wb_rst_i;

   wb_region_ctrl_if bus();

   wb_region_ctrl #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W(8)
   ) dut (
      .wb_clk_i(wb_clk_i),
      .wb_rst_i(wb_rst_i),
      .bus(bus.slave)
   );

   typedef struct {
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t        expQ[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          expAcks = 0;
   int          ackCount = 0;
   int          irqCount = 0;

   int          s0Wait = 0;
   int          s1Wait = 0;
   logic [31:0] s0Data = 32'h0;
   logic [31:0] s1Data = 32'h0;
   bit          s1Rogue = 0;
   int          s0Cnt = 0;
   int          s1Cnt = 0;

   logic [31:0] snapAdr, snapDat;
   logic [3:0]  snapSel;
   logic        snapWe;

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   // Slave responders: ack after (wait+1) negedges of strobe, or never when wait is negative.
   always @(negedge wb_clk_i) begin
      if (bus.s0_stb_o) s0Cnt++; else s0Cnt = 0;
      if (bus.s1_stb_o) s1Cnt++; else s1Cnt = 0;
      bus.s0_ack_i = bus.s0_stb_o && (s0Wait >= 0) && (s0Cnt == s0Wait + 1);
      bus.s1_ack_i = s1Rogue || (bus.s1_stb_o && (s1Wait >= 0) && (s1Cnt == s1Wait + 1));
      bus.s0_dat_i = s0Data;
      bus.s1_dat_i = s1Data;
      if (bus.wbs_ack_o === 1'b1) ackCount++;
      if (bus.err_irq_o === 1'b1) irqCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_ack"}, {31'b0, bus.wbs_ack_o}, 32'h0);
      checkOutput({tag, "_dat"}, bus.wbs_dat_o, 32'h0);
      checkOutput({tag, "_s0ctl"}, {25'b0, bus.s0_cyc_o, bus.s0_stb_o, bus.s0_we_o, bus.s0_sel_o}, 32'h0);
      checkOutput({tag, "_s0adr"}, bus.s0_adr_o | bus.s0_dat_o, 32'h0);
      checkOutput({tag, "_s1ctl"}, {25'b0, bus.s1_cyc_o, bus.s1_stb_o, bus.s1_we_o, bus.s1_sel_o}, 32'h0);
      checkOutput({tag, "_s1adr"}, bus.s1_adr_o | bus.s1_dat_o, 32'h0);
      checkOutput({tag, "_irq"}, {31'b0, bus.err_irq_o}, 32'h0);
   endtask

   // One host cycle: push the expectation, hold the request until ack (bounded), then pop and compare.
   task automatic applyStimulus(input string tag, input logic [31:0] adr, input logic we,
                                input logic [3:0] sel, input logic [31:0] wdat,
                                input logic [31:0] expData, input int expLat,
                                input logic expS0, input logic expS1);
      exp_t e;
      int   n;
      bit   got;
      logic sawS0, sawS1;
      @(negedge wb_clk_i);
      bus.wbs_adr_i = adr;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = sel;
      bus.wbs_dat_i = wdat;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      expQ.push_back('{expData, expLat});
      expAcks++;
      n = 0; got = 0; sawS0 = 1'b0; sawS1 = 1'b0;
      while (!got && n < 60) begin
         @(negedge wb_clk_i);
         n++;
         sawS0 = sawS0 | bus.s0_stb_o;
         sawS1 = sawS1 | bus.s1_stb_o;
         if (bus.s1_stb_o) begin
            snapAdr = bus.s1_adr_o; snapDat = bus.s1_dat_o; snapSel = bus.s1_sel_o; snapWe = bus.s1_we_o;
         end else if (bus.s0_stb_o) begin
            snapAdr = bus.s0_adr_o; snapDat = bus.s0_dat_o; snapSel = bus.s0_sel_o; snapWe = bus.s0_we_o;
         end
         if (bus.wbs_ack_o === 1'b1) got = 1;
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      e = expQ.pop_front();
      if (got) begin
         if (!we) checkOutput({tag, "_data"}, bus.wbs_dat_o, e.data);
         checkOutput({tag, "_lat"}, n, e.lat);
      end else begin
         checkOutput({tag, "_noack"}, 32'h0, 32'h1);
      end
      checkOutput({tag, "_s0stb"}, {31'b0, sawS0}, {31'b0, expS0});
      checkOutput({tag, "_s1stb"}, {31'b0, sawS1}, {31'b0, expS1});
   endtask

   initial begin
      wb_rst_i      = 1'b1;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;
      repeat (3) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      checkQuiet("reset");

      // Zero-wait read from the neuro slave
      s0Wait = 0; s0Data = 32'h1234_5678;
      applyStimulus("rd_s0", 32'h3000_0004, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 2, 1'b1, 1'b0);
      checkOutput("rd_s0_adr", snapAdr, 32'h3000_0004);
      checkOutput("rd_s0_we", {31'b0, snapWe}, 32'h0);

      // Zero-wait write to the matmul slave
      s1Wait = 0; s1Data = 32'h0;
      applyStimulus("wr_s1", 32'h3100_0010, 1'b1, 4'hF, 32'hA5A5_0001, 32'h0, 2, 1'b0, 1'b1);
      checkOutput("wr_s1_adr", snapAdr, 32'h3100_0010);
      checkOutput("wr_s1_dat", snapDat, 32'hA5A5_0001);
      checkOutput("wr_s1_sel", {28'b0, snapSel}, 32'hF);
      checkOutput("wr_s1_we", {31'b0, snapWe}, 32'h1);

      // Unmapped read and write
      applyStimulus("rd_unmap", 32'h3300_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1, 1'b0, 1'b0);
      applyStimulus("wr_unmap", 32'h3000_1000, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, 1'b0);

      // Wait states, with a rogue ack held on the unselected slave
      s0Wait = 3; s0Data = 32'hCAFE_0003; s1Rogue = 1; s1Data = 32'hBAD0_BAD0;
      applyStimulus("rd_s0_ws3", 32'h3000_0020, 1'b0, 4'h3, 32'h0, 32'hCAFE_0003, 5, 1'b1, 1'b0);
      s1Rogue = 0; s1Data = 32'h0;

`ifdef WBCTRL_TIMEOUT_EN
      s1Wait = -1;
      applyStimulus("to_s1", 32'h3100_0000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, TO + 1, 1'b0, 1'b1);
      applyStimulus("stat_rd1", 32'h3200_0000, 1'b0, 4'hF, 32'h0, 32'h0001_0003, 1, 1'b0, 1'b0);
      applyStimulus("stat_clr", 32'h3200_0000, 1'b1, 4'h1, 32'h1, 32'h0, 1, 1'b0, 1'b0);
      applyStimulus("stat_rd2", 32'h3200_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1, 1'b0, 1'b0);

      s0Wait = TO - 1; s0Data = 32'h0ACC_0007;
      applyStimulus("ack_at_to", 32'h3000_0000, 1'b0, 4'hF, 32'h0, 32'h0ACC_0007, TO + 1, 1'b1, 1'b0);
      applyStimulus("stat_rd3", 32'h3200_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1, 1'b0, 1'b0);

      s0Wait = -1;
      applyStimulus("to_s0", 32'h3000_0000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, TO + 1, 1'b1, 1'b0);
      applyStimulus("stat_noclr", 32'h3200_0000, 1'b1, 4'hE, 32'h1, 32'h0, 1, 1'b0, 1'b0);
      applyStimulus("stat_rd4", 32'h3200_0000, 1'b0, 4'hF, 32'h0, 32'h0001_0001, 1, 1'b0, 1'b0);
`else
      applyStimulus("stat_rd", 32'h3200_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1, 1'b0, 1'b0);
      s1Wait = 20; s1Data = 32'h5EED_0020;
      applyStimulus("rd_s1_long", 32'h3100_0004, 1'b0, 4'hF, 32'h0, 32'h5EED_0020, 22, 1'b0, 1'b1);
      applyStimulus("stat_wr", 32'h3200_0000, 1'b1, 4'h1, 32'h1, 32'h0, 1, 1'b0, 1'b0);
      applyStimulus("stat_rd2", 32'h3200_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1, 1'b0, 1'b0);
`endif

      // Host abandons the cycle while the slave stalls
      s0Wait = -1;
      @(negedge wb_clk_i);
      bus.wbs_adr_i = 32'h3000_0008; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'hF;
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
      repeat (3) @(negedge wb_clk_i);
      checkOutput("drop_pre_stb", {31'b0, bus.s0_stb_o}, 32'h1);
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      @(negedge wb_clk_i);
      checkOutput("drop_stb", {31'b0, bus.s0_stb_o}, 32'h0);
      checkOutput("drop_ack", {31'b0, bus.wbs_ack_o}, 32'h0);
      @(negedge wb_clk_i);
      checkOutput("drop_ack2", {31'b0, bus.wbs_ack_o}, 32'h0);

      s0Wait = 0; s0Data = 32'h0BAC_0001;
      applyStimulus("rd_after_drop", 32'h3000_0004, 1'b0, 4'hF, 32'h0, 32'h0BAC_0001, 2, 1'b1, 1'b0);

      // Reset lands in the middle of a stalled matmul access
      s1Wait = -1;
      @(negedge wb_clk_i);
      bus.wbs_adr_i = 32'h3100_0000; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'hF;
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
      repeat (2) @(negedge wb_clk_i);
      checkOutput("rst_pre_stb", {31'b0, bus.s1_stb_o}, 32'h1);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      checkQuiet("midrst");
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      checkQuiet("postrst");

      applyStimulus("stat_after_rst", 32'h3200_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1, 1'b0, 1'b0);

      repeat (3) @(negedge wb_clk_i);
      checkOutput("ack_total", ackCount, expAcks);
`ifdef WBCTRL_TIMEOUT_EN
      checkOutput("irq_total", irqCount, 32'd2);
`else
      checkOutput("irq_total", irqCount, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
